vga_pixel_feeder: RTL and testbench

VGA_PIXEL_FEEDER -- requirements
Module: vga_pixel_feeder

---
 rtl/vga_pixel_feeder.sv | 145 ++++++++++++++
 tb/tb_vga_pixel_feeder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_feeder.sv
// Frame-memory to VGA pixel feeder: prefetches pixels into a small FIFO and
// hands one colour to the output stage per visible pixel, black otherwise.
module vga_pixel_feeder #(
   parameter int FRAME_PIXELS = 307200,
   parameter int FIFO_DEPTH   = 16,
   parameter int PREFILL      = 8
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        frame_start_i,
   input  logic        pix_en_i,
   output logic        mem_req_o,
   output logic [18:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [11:0] mem_data_i,
   output logic [3:0]  red_o,
   output logic [3:0]  green_o,
   output logic [3:0]  blue_o,
   output logic        underflow_o,
   output logic [4:0]  fifo_level_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0]  DEPTH_L   = 5'(FIFO_DEPTH);
   localparam logic [4:0]  PREFILL_L = 5'(PREFILL);
   localparam logic [18:0] FRAME_L   = 19'(FRAME_PIXELS);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_STALL = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [4:0]       level_q, level_d;
   logic [18:0]      addr_q, addr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [11:0]      rgb_q, rgb_d;
   logic             underflow_q, underflow_d;
   logic [11:0]      fifo_mem [FIFO_DEPTH];

   logic fetching;
   logic push;
   logic pop;

   // Request depends only on registered state so it never loops through the ack path.
   assign fetching  = (state_q == ST_FILL) || (state_q == ST_RUN);
   assign mem_req_o = fetching && (level_q < DEPTH_L) && (addr_q < FRAME_L);

   // A frame start overrides any coincident ack or pop.
   assign push = mem_req_o && mem_ack_i && !frame_start_i;
   assign pop  = (state_q == ST_RUN) && pix_en_i && (level_q != 5'd0) && !frame_start_i;

   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      addr_d      = addr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rgb_d       = 12'h000;
      underflow_d = 1'b0;

      if (frame_start_i) begin
         state_d  = ST_FILL;
         level_d  = 5'd0;
         addr_d   = 19'd0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            addr_d   = addr_q + 19'd1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            rgb_d    = fifo_mem[rd_ptr_q];
         end

         case ({push, pop})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
         endcase

         case (state_q)
            ST_FILL: begin
               if (pix_en_i) begin
                  underflow_d = 1'b1;
                  state_d     = ST_STALL;
               end else if (level_d >= PREFILL_L) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (pix_en_i && (level_q == 5'd0)) begin
                  underflow_d = 1'b1;
                  state_d     = ST_STALL;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= ST_IDLE;
         level_q     <= 5'd0;
         addr_q      <= 19'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rgb_q       <= 12'h000;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         addr_q      <= addr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rgb_q       <= rgb_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage has no reset; occupancy is tracked by the pointers and level.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= mem_data_i;
      end
   end

   logic [3:0] chan [3];

   for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign chan[gi] = rgb_q[4*gi +: 4];
   end

   assign blue_o       = chan[0];
   assign green_o      = chan[1];
   assign red_o        = chan[2];
   assign underflow_o  = underflow_q;
   assign fifo_level_o = level_q;
   assign mem_addr_o   = addr_q;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Randomised bench for vga_pixel_feeder against a queue-based model of the
// feeder, plus literal expectations for the directed scenarios.
module tb_vga_pixel_feeder;

   localparam int FP = 600;
   localparam int FD = 16;
   localparam int PF = 8;

   localparam int M_IDLE  = 0;
   localparam int M_FILL  = 1;
   localparam int M_RUN   = 2;
   localparam int M_STALL = 3;

   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        frame_start_i = 1'b0;
   logic        pix_en_i = 1'b0;
   logic        mem_ack_i = 1'b0;
   logic [11:0] mem_data_i = 12'h000;
   logic        mem_req_o;
   logic [18:0] mem_addr_o;
   logic [3:0]  red_o, green_o, blue_o;
   logic        underflow_o;
   logic [4:0]  fifo_level_o;

   vga_pixel_feeder #(.FRAME_PIXELS(FP), .FIFO_DEPTH(FD), .PREFILL(PF)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .frame_start_i(frame_start_i),
      .pix_en_i(pix_en_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .red_o(red_o),
      .green_o(green_o), .blue_o(blue_o), .underflow_o(underflow_o),
      .fifo_level_o(fifo_level_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;

   logic [11:0] q [$];
   int          m_addr = 0;
   int          m_mode = M_IDLE;
   logic [11:0] m_rgb = 12'h000;
   logic        m_uf = 1'b0;
   int          pops = 0;
   int          ufs = 0;
   int          last_acked = -1;

   function automatic bit m_req();
      return ((m_mode == M_FILL) || (m_mode == M_RUN)) && (q.size() < FD) && (m_addr < FP);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_addr = 0;
      m_mode = M_IDLE;
      m_rgb  = 12'h000;
      m_uf   = 1'b0;
   endtask

   task automatic model_tick();
      bit req;
      bit pop;
      req   = m_req();
      pop   = 1'b0;
      m_rgb = 12'h000;
      m_uf  = 1'b0;
      if (frame_start_i) begin
         q.delete();
         m_addr = 0;
         m_mode = M_FILL;
         return;
      end
      if (pix_en_i && m_mode == M_RUN) begin
         if (q.size() > 0) pop = 1'b1;
         else begin
            m_uf = 1'b1; m_mode = M_STALL; ufs++;
         end
      end else if (pix_en_i && m_mode == M_FILL) begin
         m_uf = 1'b1; m_mode = M_STALL; ufs++;
      end
      if (pop) begin
         m_rgb = q.pop_front();
         pops++;
      end
      if (req && mem_ack_i) begin
         q.push_back(mem_data_i);
         last_acked = m_addr;
         m_addr++;
      end
      if (m_mode == M_FILL && q.size() >= PF) m_mode = M_RUN;
   endtask

   task automatic cmp_all();
      check("rgb", int'({red_o, green_o, blue_o}), int'(m_rgb));
      check("underflow", int'(underflow_o), int'(m_uf));
      check("level", int'(fifo_level_o), q.size());
      check("req", int'(mem_req_o), int'(m_req()));
      check("addr", int'(mem_addr_o), m_addr);
   endtask

   task automatic step();
      @(posedge clk_i);
      if (!reset_ni) model_reset();
      else model_tick();
      @(negedge clk_i);
      cmp_all();
   endtask

   task automatic idle_inputs();
      frame_start_i = 1'b0;
      pix_en_i      = 1'b0;
      mem_ack_i     = 1'b0;
   endtask

   task automatic start_frame();
      idle_inputs();
      frame_start_i = 1'b1;
      step();
      frame_start_i = 1'b0;
   endtask

   initial begin
      int  abc_seen;
      int  cyc;
      bit  seen_run;
      bit  run_seen;

      model_reset();
      repeat (3) step();
      reset_ni = 1'b1;

      // Idle after reset: nothing may move without a frame start.
      for (int i = 0; i < 100; i++) begin
         pix_en_i   = 1'($urandom);
         mem_ack_i  = 1'($urandom);
         mem_data_i = 12'($urandom);
         step();
      end
      idle_inputs();
      check("idle_req", int'(mem_req_o), 0);
      check("idle_level", int'(fifo_level_o), 0);
      check("idle_rgb", int'({red_o, green_o, blue_o}), 0);
      $display("phase idle: checks=%0d", checks);

      // Prefill with data equal to address, then three pixels.
      start_frame();
      seen_run = 1'b0;
      for (int i = 0; i < 40 && fifo_level_o != 5'd16; i++) begin
         mem_ack_i  = 1'b1;
         mem_data_i = 12'(m_addr);
         step();
         if (m_mode == M_RUN && !seen_run) begin
            seen_run = 1'b1;
            check("run_entry_level", int'(fifo_level_o), 8);
         end
      end
      check("prefill_full", int'(fifo_level_o), 16);
      for (int i = 0; i < 3; i++) begin
         step();
         check("full_req_low", int'(mem_req_o), 0);
      end
      mem_ack_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pix_en_i = 1'b1;
         step();
         check("first_pixels", int'({red_o, green_o, blue_o}), i);
      end
      pix_en_i = 1'b0;
      step();
      check("black_after_pixels", int'({red_o, green_o, blue_o}), 0);
      check("level_after_pixels", int'(fifo_level_o), 13);
      $display("phase prefill: checks=%0d failures=%0d", checks, failures);

      // Whole (reduced) frame with an ack every cycle.
      start_frame();
      pops = 0; ufs = 0; last_acked = -1;
      for (int i = 0; i < FP + 200 && pops < FP; i++) begin
         mem_ack_i  = 1'b1;
         mem_data_i = 12'($urandom);
         pix_en_i   = (m_mode == M_RUN) && (pops < FP);
         step();
      end
      idle_inputs();
      repeat (4) step();
      check("frame_pops", pops, FP);
      check("frame_underflows", ufs, 0);
      check("frame_last_addr", last_acked, FP - 1);
      check("frame_end_req", int'(mem_req_o), 0);
      check("frame_end_addr", int'(mem_addr_o), FP);
      $display("phase full frame: pops=%0d", pops);

      // Slow memory: underflow once, then stall until the next frame.
      start_frame();
      ufs = 0; run_seen = 1'b0; cyc = 0;
      for (int i = 0; i < 200; i++) begin
         mem_ack_i  = (cyc % 4 == 0);
         mem_data_i = 12'($urandom);
         if (m_mode == M_RUN) run_seen = 1'b1;
         pix_en_i = run_seen;
         step();
         cyc++;
      end
      check("slow_underflows", ufs, 1);
      check("slow_stall_req", int'(mem_req_o), 0);
      check("slow_stall_rgb", int'({red_o, green_o, blue_o}), 0);
      start_frame();
      check("refill_addr", int'(mem_addr_o), 0);
      check("refill_req", int'(mem_req_o), 1);
      $display("phase slow memory: underflows=%0d", ufs);

      // Frame start colliding with an ack at level 5.
      for (int i = 0; i < 20 && fifo_level_o != 5'd5; i++) begin
         mem_ack_i  = 1'b1;
         mem_data_i = 12'h123;
         step();
      end
      check("collide_pre_level", int'(fifo_level_o), 5);
      frame_start_i = 1'b1;
      mem_ack_i     = 1'b1;
      mem_data_i    = 12'hABC;
      step();
      frame_start_i = 1'b0;
      check("collide_level", int'(fifo_level_o), 0);
      check("collide_addr", int'(mem_addr_o), 0);
      abc_seen = 0;
      for (int i = 0; i < 60; i++) begin
         mem_ack_i  = 1'b1;
         mem_data_i = 12'h123;
         pix_en_i   = (m_mode == M_RUN) && (i % 2 == 0);
         step();
         if ({red_o, green_o, blue_o} == 12'hABC) abc_seen++;
      end
      idle_inputs();
      check("collide_data_dropped", abc_seen, 0);
      $display("phase collision: checks=%0d failures=%0d", checks, failures);

      // Asynchronous reset with level 12 in RUN.
      start_frame();
      for (int i = 0; i < 40 && fifo_level_o != 5'd16; i++) begin
         mem_ack_i  = 1'b1;
         mem_data_i = 12'($urandom);
         step();
      end
      mem_ack_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pix_en_i = 1'b1;
         step();
      end
      pix_en_i = 1'b0;
      check("pre_reset_level", int'(fifo_level_o), 12);
      #2 reset_ni = 1'b0;
      #1;
      check("async_req", int'(mem_req_o), 0);
      check("async_addr", int'(mem_addr_o), 0);
      check("async_level", int'(fifo_level_o), 0);
      check("async_rgb", int'({red_o, green_o, blue_o}), 0);
      check("async_uf", int'(underflow_o), 0);
      model_reset();
      step();
      reset_ni = 1'b1;
      for (int i = 0; i < 5; i++) begin
         mem_ack_i = 1'b1;
         pix_en_i  = 1'($urandom);
         step();
      end
      idle_inputs();
      check("post_reset_req", int'(mem_req_o), 0);
      $display("phase async reset: checks=%0d failures=%0d", checks, failures);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         frame_start_i = ($urandom_range(0, 199) == 0);
         pix_en_i      = ($urandom_range(0, 2) != 0);
         mem_ack_i     = ($urandom_range(0, 3) != 0);
         mem_data_i    = 12'($urandom);
         step();
      end
      idle_inputs();
      $display("phase random: checks=%0d failures=%0d", checks, failures);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
